// File: rtl/adc_spi_master_if.sv
// Command-side bundle between the register-config block and the ADC SPI master.
// The master modport is the requester; the slave modport is the SPI engine.
interface adc_spi_master_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic [15:0]       clk_div_cnt;
    logic              spi_addr_2byte;
    logic              cmd_write;
    logic              cmd_read;
    logic [ADDR_W-1:0] write_addr;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] write_data;
    logic              cmd_write_ack;
    logic              cmd_read_ack;
    logic [DATA_W-1:0] read_data;
    logic              busy;

    modport master (
        output clk_div_cnt, spi_addr_2byte, cmd_write, cmd_read,
               write_addr, read_addr, write_data,
        input  cmd_write_ack, cmd_read_ack, read_data, busy
    );

    modport slave (
        input  clk_div_cnt, spi_addr_2byte, cmd_write, cmd_read,
               write_addr, read_addr, write_data,
        output cmd_write_ack, cmd_read_ack, read_data, busy
    );
endinterface

// File: rtl/adc_spi_master.sv
// 3-wire SPI master for single-register ADC writes and reads.
// Sends {RW, address} plus one data byte MSB-first and turns the data line around for reads.
module adc_spi_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    adc_spi_master_if.slave  bus,
    output logic             spi_ce,
    output logic             spi_sclk,
    output logic             spi_dir,
    output logic             spi_out,
    input  logic             spi_in
);

    localparam int         FRAME_W  = 16 + DATA_W;
    localparam logic [5:0] LEN_1B   = 6'(8 + DATA_W);
    localparam logic [5:0] LEN_2B   = 6'(16 + DATA_W);
    localparam logic [5:0] INSTR_1B = 6'd8;
    localparam logic [5:0] INSTR_2B = 6'd16;

    typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, ACK} state_t;

    state_t             state;
    logic [15:0]        timer;
    logic [15:0]        h_m1;
    logic [5:0]         bit_idx;
    logic [5:0]         frame_len;
    logic [5:0]         instr_len;
    logic               is_read;
    logic               rearm;
    logic [FRAME_W-1:0] shreg;
    logic [DATA_W-1:0]  rx;

    logic               sel_read;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [FRAME_W-1:0] load_word;
    logic [15:0]        load_h_m1;

    // Frame is built left-aligned so the 1-byte mode simply runs out of bits earlier.
    always_comb begin
        sel_read  = !bus.cmd_write;
        sel_addr  = bus.cmd_write ? bus.write_addr : bus.read_addr;
        sel_data  = bus.cmd_write ? bus.write_data : '0;
        load_word = '0;
        if (bus.spi_addr_2byte)
            load_word = {sel_read, {(15 - ADDR_W){1'b0}}, sel_addr, sel_data};
        else
            load_word = {sel_read, sel_addr[6:0], sel_data, 8'h00};
        load_h_m1 = (bus.clk_div_cnt == 16'd0) ? 16'd0 : bus.clk_div_cnt - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            timer             <= '0;
            h_m1              <= '0;
            bit_idx           <= '0;
            frame_len         <= LEN_1B;
            instr_len         <= INSTR_1B;
            is_read           <= 1'b0;
            rearm             <= 1'b1;
            shreg             <= '0;
            rx                <= '0;
            spi_ce            <= 1'b1;
            spi_sclk          <= 1'b0;
            spi_dir           <= 1'b1;
            spi_out           <= 1'b0;
            bus.cmd_write_ack <= 1'b0;
            bus.cmd_read_ack  <= 1'b0;
            bus.read_data     <= '0;
            bus.busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rearm && (bus.cmd_write || bus.cmd_read)) begin
                        state     <= SETUP;
                        rearm     <= 1'b0;
                        bus.busy  <= 1'b1;
                        is_read   <= sel_read;
                        shreg     <= load_word;
                        spi_out   <= load_word[FRAME_W-1];
                        spi_ce    <= 1'b0;
                        spi_dir   <= 1'b1;
                        timer     <= load_h_m1;
                        h_m1      <= load_h_m1;
                        bit_idx   <= '0;
                        frame_len <= bus.spi_addr_2byte ? LEN_2B : LEN_1B;
                        instr_len <= bus.spi_addr_2byte ? INSTR_2B : INSTR_1B;
                    end else if (!bus.cmd_write && !bus.cmd_read) begin
                        rearm <= 1'b1;
                    end
                end
                SETUP: begin
                    if (timer == 16'd0) begin
                        state    <= SCLK_HI;
                        spi_sclk <= 1'b1;
                        timer    <= h_m1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                SCLK_HI: begin
                    if (is_read && timer == h_m1 && bit_idx >= instr_len)
                        rx <= {rx[DATA_W-2:0], spi_in};
                    if (timer == 16'd0) begin
                        state    <= SCLK_LO;
                        spi_sclk <= 1'b0;
                        timer    <= h_m1;
                        bit_idx  <= bit_idx + 6'd1;
                        shreg    <= shreg << 1;
                        // Once the last instruction bit has been clocked, a read hands the line to the ADC.
                        if (is_read && (bit_idx + 6'd1) >= instr_len) begin
                            spi_dir <= 1'b0;
                            spi_out <= 1'b0;
                        end else begin
                            spi_out <= shreg[FRAME_W-2];
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                SCLK_LO: begin
                    if (timer == 16'd0) begin
                        timer <= h_m1;
                        if (bit_idx == frame_len) begin
                            state   <= HOLD;
                            spi_ce  <= 1'b1;
                            spi_dir <= 1'b1;
                            spi_out <= 1'b0;
                        end else begin
                            state    <= SCLK_HI;
                            spi_sclk <= 1'b1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                HOLD: begin
                    if (timer == 16'd0) begin
                        state <= ACK;
                        if (is_read) begin
                            bus.cmd_read_ack <= 1'b1;
                            bus.read_data    <= rx;
                        end else begin
                            bus.cmd_write_ack <= 1'b1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ACK: begin
                    state             <= IDLE;
                    bus.cmd_write_ack <= 1'b0;
                    bus.cmd_read_ack  <= 1'b0;
                    bus.busy          <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: a cycle-timeline model derived from the frame arithmetic,
// an ADC responder that reacts to the DUT's SCLK, and directed plus random transactions.
module tb_adc_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic spi_ce, spi_sclk, spi_dir, spi_out;
    logic spi_in = 1'b0;

    adc_spi_master_if ifc ();

    adc_spi_master dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc.slave),
        .spi_ce   (spi_ce),
        .spi_sclk (spi_sclk),
        .spi_dir  (spi_dir),
        .spi_out  (spi_out),
        .spi_in   (spi_in)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the transaction timeline relative to its accept cycle.
    logic        m_valid  = 1'b0;
    logic        m_active = 1'b0;
    logic        m_rearm  = 1'b1;
    logic        m_rw     = 1'b0;
    int          m_k      = 0;
    int          m_h      = 1;
    int          m_n      = 16;
    int          m_e      = 0;
    logic [23:0] m_word   = '0;
    logic [7:0]  m_rd     = '0;
    logic [7:0]  m_adc    = '0;

    logic [7:0]  adc_byte  = '0;
    int          adc_instr = 16;

    int          cyc = 0, mon_start = 0, rises = 0;
    int          last_lat = 0, last_rises = 0, wack_cnt = 0, rack_cnt = 0;
    logic [23:0] frame = '0, dirs = '0, last_frame = '0, last_dirs = '0;
    logic        prev_busy = 1'b0, prev_sclk = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [23:0] build_word(input logic rw, input logic two,
                                               input logic [12:0] addr, input logic [7:0] data);
        if (two) return {rw, 2'b00, addr, data};
        return {rw, addr[6:0], data, 8'h00};
    endfunction

    function automatic logic model_bit(input int b);
        if (b >= m_n) return 1'b0;
        return m_word[23 - b];
    endfunction

    // Pins for the current cycle: SETUP for H cycles, 2H per bit (HI then LO), HOLD for H, one ACK cycle.
    function automatic logic [14:0] expected_pins();
        logic ce, sclk, dir, out, wa, ra;
        int j, b;
        ce = 1'b1; sclk = 1'b0; dir = 1'b1; out = 1'b0; wa = 1'b0; ra = 1'b0;
        if (m_active) begin
            if (m_k <= m_h) begin
                ce  = 1'b0;
                out = model_bit(0);
            end else if (m_k <= m_h + 2 * m_n * m_h) begin
                j  = m_k - m_h - 1;
                b  = j / (2 * m_h);
                ce = 1'b0;
                if ((j % (2 * m_h)) < m_h) begin
                    sclk = 1'b1;
                    if (m_rw && b >= m_n - 8) dir = 1'b0;
                    else out = model_bit(b);
                end else begin
                    if (m_rw && b >= m_n - 9) dir = 1'b0;
                    else out = model_bit(b + 1);
                end
            end else if (m_k == m_e) begin
                wa = !m_rw;
                ra = m_rw;
            end
        end
        return {ce, sclk, dir, out, m_active, wa, ra, m_rd};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_valid  <= 1'b1;
            m_active <= 1'b0;
            m_rearm  <= 1'b1;
            m_rd     <= '0;
        end else if (m_active) begin
            if (m_k == m_e) begin
                m_active <= 1'b0;
            end else begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_e && m_rw) m_rd <= m_adc;
            end
        end else if (m_rearm && (ifc.cmd_write || ifc.cmd_read)) begin
            m_active <= 1'b1;
            m_rearm  <= 1'b0;
            m_k      <= 1;
            m_rw     <= !ifc.cmd_write;
            m_adc    <= adc_byte;
            m_h      <= (ifc.clk_div_cnt == 16'd0) ? 1 : int'(ifc.clk_div_cnt);
            m_n      <= ifc.spi_addr_2byte ? 24 : 16;
            m_e      <= (2 * (ifc.spi_addr_2byte ? 24 : 16) + 2)
                        * ((ifc.clk_div_cnt == 16'd0) ? 1 : int'(ifc.clk_div_cnt)) + 1;
            m_word   <= ifc.cmd_write
                        ? build_word(1'b0, ifc.spi_addr_2byte, ifc.write_addr, ifc.write_data)
                        : build_word(1'b1, ifc.spi_addr_2byte, ifc.read_addr, 8'h00);
        end else if (!ifc.cmd_write && !ifc.cmd_read) begin
            m_rearm <= 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid)
            checkOutput("pins", 32'({spi_ce, spi_sclk, spi_dir, spi_out, ifc.busy,
                                     ifc.cmd_write_ack, ifc.cmd_read_ack, ifc.read_data}),
                        32'(expected_pins()));
    end

    // Monitor and ADC responder: the ADC presents data bit d right after the rising edge that follows its instruction.
    initial forever begin
        int d;
        logic [31:0] junk;
        @(negedge clk);
        cyc++;
        if (ifc.busy && !prev_busy) begin
            mon_start = cyc;
            rises = 0;
            frame = '0;
            dirs  = '0;
        end
        if (spi_sclk && !prev_sclk) begin
            rises++;
            frame = {frame[22:0], spi_out};
            dirs  = {dirs[22:0], spi_dir};
            d = rises - 1 - adc_instr;
            if (d >= 0 && d < 8) begin
                spi_in = adc_byte[7 - d];
            end else begin
                junk = $urandom;
                spi_in = junk[0];
            end
        end
        if (ifc.cmd_write_ack) wack_cnt++;
        if (ifc.cmd_read_ack)  rack_cnt++;
        if (ifc.cmd_write_ack || ifc.cmd_read_ack) begin
            last_lat   = cyc - mon_start + 1;
            last_frame = frame;
            last_dirs  = dirs;
            last_rises = rises;
        end
        prev_busy = ifc.busy;
        prev_sclk = spi_sclk;
    end

    task automatic wait_ack(input logic rd, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rd ? ifc.cmd_read_ack : ifc.cmd_write_ack) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("ack_seen", 32'(seen), 32'd1);
    endtask

    task automatic applyStimulus(input logic rw, input logic [15:0] div, input logic two,
                                 input logic [12:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] adc, input int hold, input logic scramble);
        @(posedge clk); #1;
        ifc.clk_div_cnt    = div;
        ifc.spi_addr_2byte = two;
        if (rw) ifc.read_addr = addr;
        else    ifc.write_addr = addr;
        ifc.write_data = wdata;
        adc_byte  = adc;
        adc_instr = two ? 16 : 8;
        if (rw) ifc.cmd_read = 1'b1;
        else    ifc.cmd_write = 1'b1;
        if (scramble) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (ifc.busy) break;
            end
            @(posedge clk); #1;
            ifc.clk_div_cnt    = 16'($urandom_range(0, 5));
            ifc.spi_addr_2byte = 1'($urandom_range(0, 1));
            ifc.write_addr     = 13'($urandom);
            ifc.read_addr      = 13'($urandom);
            ifc.write_data     = 8'($urandom);
        end
        wait_ack(rw, 3000);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        ifc.cmd_write = 1'b0;
        ifc.cmd_read  = 1'b0;
    endtask

    initial begin
        int w0, r0;
        logic rw, two;
        logic [15:0] div;
        logic [12:0] addr;
        logic [7:0] wd, adc;
        int hold, gap;

        ifc.clk_div_cnt    = 16'd1;
        ifc.spi_addr_2byte = 1'b1;
        ifc.cmd_write      = 1'b0;
        ifc.cmd_read       = 1'b0;
        ifc.write_addr     = '0;
        ifc.read_addr      = '0;
        ifc.write_data     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 32'({spi_ce, spi_sclk, spi_dir, spi_out, ifc.busy,
                                        ifc.cmd_write_ack, ifc.cmd_read_ack, ifc.read_data}),
                    32'h5000);
        @(posedge clk); #1 rst = 1'b1;

        $display("[TB] T1 2-byte write, H=4");
        applyStimulus(1'b0, 16'd4, 1'b1, 13'h0014, 8'hA5, 8'h00, 0, 1'b0);
        checkOutput("t1_latency", 32'(last_lat), 32'd201);
        checkOutput("t1_frame", 32'(last_frame), 32'h0014A5);
        checkOutput("t1_dir", 32'(last_dirs), 32'hFFFFFF);
        checkOutput("t1_rises", 32'(last_rises), 32'd24);

        $display("[TB] T2 2-byte read, H=2");
        applyStimulus(1'b1, 16'd2, 1'b1, 13'h001F, 8'h00, 8'h01, 0, 1'b0);
        checkOutput("t2_latency", 32'(last_lat), 32'd101);
        checkOutput("t2_instr", 32'(last_frame[23:8]), 32'h801F);
        checkOutput("t2_dir", 32'(last_dirs), 32'hFFFF00);
        checkOutput("t2_read_data", 32'(ifc.read_data), 32'h01);

        $display("[TB] T3 1-byte write, clk_div_cnt=0");
        applyStimulus(1'b0, 16'd0, 1'b0, 13'h1F55, 8'h3C, 8'h00, 0, 1'b0);
        checkOutput("t3_latency", 32'(last_lat), 32'd35);
        checkOutput("t3_frame", 32'(last_frame[15:0]), 32'h553C);
        checkOutput("t3_rises", 32'(last_rises), 32'd16);
        checkOutput("t3_read_data_kept", 32'(ifc.read_data), 32'h01);

        $display("[TB] T4 simultaneous write and read");
        w0 = wack_cnt; r0 = rack_cnt;
        @(posedge clk); #1;
        ifc.clk_div_cnt = 16'd1; ifc.spi_addr_2byte = 1'b1;
        ifc.write_addr = 13'h0ABC; ifc.write_data = 8'h5A; ifc.read_addr = 13'h0123;
        adc_byte = 8'hC3; adc_instr = 16;
        ifc.cmd_write = 1'b1; ifc.cmd_read = 1'b1;
        wait_ack(1'b0, 3000);
        @(posedge clk); #1 ifc.cmd_write = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_read_not_started", 32'(ifc.busy), 32'd0);
        @(posedge clk); #1 ifc.cmd_read = 1'b0;
        @(posedge clk); #1 ifc.cmd_read = 1'b1;
        wait_ack(1'b1, 3000);
        @(posedge clk); #1 ifc.cmd_read = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("t4_write_acks", 32'(wack_cnt - w0), 32'd1);
        checkOutput("t4_read_acks", 32'(rack_cnt - r0), 32'd1);
        checkOutput("t4_read_data", 32'(ifc.read_data), 32'hC3);

        $display("[TB] T5 write request held past ack");
        w0 = wack_cnt;
        applyStimulus(1'b0, 16'd1, 1'b0, 13'h0011, 8'h77, 8'h00, 3, 1'b0);
        repeat (8) @(posedge clk);
        checkOutput("t5_write_acks", 32'(wack_cnt - w0), 32'd1);

        $display("[TB] T6 reset during a read");
        @(posedge clk); #1;
        ifc.clk_div_cnt = 16'd1; ifc.spi_addr_2byte = 1'b1; ifc.read_addr = 13'h0042;
        adc_byte = 8'h99; adc_instr = 16;
        ifc.cmd_read = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rises == 10 && ifc.busy) break;
        end
        checkOutput("t6_reached_bit10", 32'(rises), 32'd10);
        r0 = rack_cnt;
        @(posedge clk); #1;
        rst = 1'b0; ifc.cmd_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_after_reset", 32'({spi_ce, spi_sclk, spi_dir, ifc.busy, ifc.read_data}), 32'hA00);
        @(posedge clk); #1 rst = 1'b1;
        repeat (60) @(posedge clk);
        checkOutput("t6_no_ack", 32'(rack_cnt - r0), 32'd0);
        applyStimulus(1'b1, 16'd3, 1'b0, 13'h0033, 8'h00, 8'h6E, 0, 1'b0);
        checkOutput("t6_new_read", 32'(ifc.read_data), 32'h6E);
        checkOutput("t6_latency", 32'(last_lat), 32'd103);

        $display("[TB] random transactions");
        for (int i = 0; i < 30; i++) begin
            rw   = 1'($urandom_range(0, 1));
            div  = 16'($urandom_range(0, 5));
            two  = 1'($urandom_range(0, 1));
            addr = 13'($urandom);
            wd   = 8'($urandom);
            adc  = 8'($urandom);
            hold = $urandom_range(0, 2);
            gap  = $urandom_range(0, 3);
            applyStimulus(rw, div, two, addr, wd, adc, hold, 1'b1);
            if (rw) checkOutput("rand_read_data", 32'(ifc.read_data), 32'(adc));
            repeat (gap) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
